// File: rtl/bin2bcd_disp_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_disp_seq
// Purpose  : Signed 16-bit to sign + 5-digit BCD converter (double-dabble),
//            optional leading-zero blanking under DISP_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================

package bin2bcd_disp_seq_pkg;
    typedef enum logic [3:0] {
        TEN = 4'hA,
        OFF = 4'hF
    } segment_e;
endpackage

module bin2bcd_disp_seq
    import bin2bcd_disp_seq_pkg::*;
#(
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_digit0,
    output logic [3:0]  o_digit1,
    output logic [3:0]  o_digit2,
    output logic [3:0]  o_digit3,
    output logic [3:0]  o_digit4,
    output segment_e    o_sign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] mag_q;
    logic [19:0] bcd_q;
    logic        neg_q;
    logic        busy_q;
    logic        done_q;
    logic [19:0] digits_q;
    segment_e    sign_q;

    logic [19:0] w_bcd_adj;
    logic [19:0] bcd_d;
    logic [15:0] mag_d;
    logic [4:0]  w_blank;
    logic [19:0] w_disp;
    logic        w_unused_msb;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                          bcd_q[gi*4 +: 4] + 4'd3 :
                                          bcd_q[gi*4 +: 4];
        end
    endgenerate

    // Max magnitude 32768 keeps the top accumulator bit clear, so it drops out
    assign bcd_d        = {w_bcd_adj[18:0], mag_q[15]};
    assign mag_d        = {mag_q[14:0], 1'b0};
    assign w_unused_msb = w_bcd_adj[19];

    always_comb begin
        w_blank = '0;
`ifdef DISP_BLANK_EN
        w_blank[4] = (bcd_d[19:16] == 4'd0);
        w_blank[3] = w_blank[4] && (bcd_d[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (bcd_d[11:8]  == 4'd0);
        w_blank[1] = w_blank[2] && (bcd_d[7:4]   == 4'd0);
`endif
    end

    generate
        for (genvar gd = 0; gd < 5; gd++) begin : g_disp
            assign w_disp[gd*4 +: 4] = w_blank[gd] ? BLANK_CODE : bcd_d[gd*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            mag_q    <= 16'd0;
            bcd_q    <= 20'd0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= 20'd0;
            sign_q   <= OFF;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        mag_q   <= i_data[15] ? (~i_data + 16'd1) : i_data;
                        neg_q   <= i_data[15];
                        bcd_q   <= 20'd0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        digits_q <= w_disp;
                        sign_q   <= neg_q ? TEN : OFF;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_digit0 = digits_q[3:0];
    assign o_digit1 = digits_q[7:4];
    assign o_digit2 = digits_q[11:8];
    assign o_digit3 = digits_q[15:12];
    assign o_digit4 = digits_q[19:16];
    assign o_sign   = sign_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_disp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_disp_seq
// Purpose  : Directed self-checking bench for bin2bcd_disp_seq.
// Revision : 1.0  initial release
// ============================================================================

module tb_bin2bcd_disp_seq;
    import bin2bcd_disp_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_data;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_digit0, o_digit1, o_digit2, o_digit3, o_digit4;
    segment_e    o_sign;

    int total;
    int bad;
    int cyc;

`ifdef DISP_BLANK_EN
    localparam bit c_BLK = 1'b1;
`else
    localparam bit c_BLK = 1'b0;
`endif

    bin2bcd_disp_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_digit0 (o_digit0),
        .o_digit1 (o_digit1),
        .o_digit2 (o_digit2),
        .o_digit3 (o_digit3),
        .o_digit4 (o_digit4),
        .o_sign   (o_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] disp();
        return {o_digit4, o_digit3, o_digit2, o_digit1, o_digit0};
    endfunction

    function automatic logic [19:0] pick(input logic [19:0] plain, input logic [19:0] blanked);
        return c_BLK ? blanked : plain;
    endfunction

    // Returns with time just after the edge that raised o_done (or after the budget)
    task automatic run_conv(input logic [15:0] d, input int inj_k, input logic [15:0] inj_d,
                            output int lat, output int busy_cnt, output int both);
        @(negedge clk);
        i_start = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        i_start  = 1'b0;
        lat      = 99;
        busy_cnt = o_busy ? 1 : 0;
        both     = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_k) begin
                i_start = 1'b1;
                i_data  = inj_d;
            end
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_busy && o_done) both++;
            if (o_done) begin
                lat = k;
                break;
            end
        end
    endtask

    logic [15:0] v_in  [4];
    logic [19:0] v_pln [4];
    logic [19:0] v_blk [4];
    logic [3:0]  v_sgn [4];

    initial begin
        int lat, bc, both, c1, nd;

        v_in[0] = 16'd32767;  v_pln[0] = 20'h32767; v_blk[0] = 20'h32767; v_sgn[0] = 4'hF;
        v_in[1] = 16'hFFF7;   v_pln[1] = 20'h00009; v_blk[1] = 20'hFFFF9; v_sgn[1] = 4'hA;
        v_in[2] = 16'd10000;  v_pln[2] = 20'h10000; v_blk[2] = 20'h10000; v_sgn[2] = 4'hF;
        v_in[3] = 16'd9999;   v_pln[3] = 20'h09999; v_blk[3] = 20'hF9999; v_sgn[3] = 4'hF;

        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_data  = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_digits", 32'(disp()), 32'h00000);
        check("rst_sign", 32'(o_sign), 32'hF);

        run_conv(16'd1234, 0, 16'd0, lat, bc, both);
        check("1234_lat", 32'(lat), 32'd16);
        check("1234_busy", 32'(bc), 32'd16);
        check("1234_overlap", 32'(both), 32'd0);
        check("1234_digits", 32'(disp()), 32'(pick(20'h01234, 20'hF1234)));
        check("1234_sign", 32'(o_sign), 32'hF);

        run_conv(16'h8000, 0, 16'd0, lat, bc, both);
        c1 = cyc;
        check("m32768_lat", 32'(lat), 32'd16);
        check("m32768_digits", 32'(disp()), 32'h32768);
        check("m32768_sign", 32'(o_sign), 32'hA);

        run_conv(16'hFFFF, 0, 16'd0, lat, bc, both);
        check("b2b_spacing", 32'(cyc - c1), 32'd17);
        check("m1_digits", 32'(disp()), 32'(pick(20'h00001, 20'hFFFF1)));
        check("m1_sign", 32'(o_sign), 32'hA);

        run_conv(16'd500, 5, 16'd999, lat, bc, both);
        check("ign_lat", 32'(lat), 32'd16);
        check("ign_busy", 32'(bc), 32'd16);
        check("ign_digits", 32'(disp()), 32'(pick(20'h00500, 20'hFF500)));
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (o_done) nd++;
        end
        check("ign_extra_done", 32'(nd), 32'd0);
        check("ign_hold", 32'(disp()), 32'(pick(20'h00500, 20'hFF500)));

        @(negedge clk);
        i_start = 1'b1;
        i_data  = 16'd7;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_done", 32'(o_done), 32'd0);
        check("mrst_digits", 32'(disp()), 32'h00000);
        check("mrst_sign", 32'(o_sign), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (o_done) nd++;
        end
        check("mrst_no_done", 32'(nd), 32'd0);
        check("mrst_hold", 32'(disp()), 32'h00000);

        run_conv(16'd0, 0, 16'd0, lat, bc, both);
        check("zero_lat", 32'(lat), 32'd16);
        check("zero_digits", 32'(disp()), 32'(pick(20'h00000, 20'hFFFF0)));
        check("zero_sign", 32'(o_sign), 32'hF);

        for (int i = 0; i < 4; i++) begin
            run_conv(v_in[i], 0, 16'd0, lat, bc, both);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd16);
            check($sformatf("vec%0d_digits", i), 32'(disp()), 32'(pick(v_pln[i], v_blk[i])));
            check($sformatf("vec%0d_sign", i), 32'(o_sign), 32'(v_sgn[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bin2bcd_disp_seq.md
# bin2bcd_disp_seq

- Sequential controller that converts a signed 16-bit result into sign plus five BCD digits for the seven-segment display path.
- Per request: takes the two's-complement magnitude and sign of `i_data`, runs a 16-iteration shift-add-3 (double-dabble) conversion, then publishes registered digits and a `segment_e` sign code.
- Sits between the ALU result register and the display multiplexer.
- Uses a start/busy/done handshake.

## Interface
- `BLANK_CODE`, default `4'hF`: digit code driven for blanked leading positions; used only when `DISP_BLANK_EN` is defined.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain.
- `i_start`  in  1  conversion request; sampled only in IDLE or DONE.
- `i_data`  in  16 (`int16_t`)  signed operand; sampled on the edge that accepts `i_start`.
- `o_busy`  out  1  high while in SHIFT.
- `o_done`  out  1  one-cycle pulse; outputs are valid from this cycle on.
- `o_digit0`..`o_digit4`  out  4 each  BCD digits; `digit0` is units, `digit4` is ten-thousands.
- `o_sign`  out  `segment_e`  `TEN` (minus glyph) if the sampled value was negative, else `OFF`.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - On `i_start=1`, latch the magnitude into a 16-bit shift register.
    - Magnitude is `~i_data+1` if `i_data[15]`, else `i_data`.
  - Latch the sign flag, clear the 20-bit BCD accumulator, set `cnt=0`, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:**
  - Each cycle, add 3 to every BCD nibble that is ≥5.
  - Then shift {BCD, magnitude} left by one and increment `cnt`.
  - After the iteration with `cnt==15`, go to DONE.
  - In the same edge, load the output registers from the final accumulator and the sign flag.
- **DONE:**
  - `o_done=1` for exactly this cycle.
  - `i_start=1` here is accepted exactly as in IDLE (back-to-back), going to SHIFT; otherwise go to IDLE.
- `i_start` during SHIFT is ignored. It is not queued, and `i_data` is not resampled.
- **Arithmetic:**
  - The magnitude is treated as unsigned 16-bit.
  - -32768 gives magnitude `0x8000`, which converts to digits 3,2,7,6,8 with `o_sign=TEN`.
  - The maximum magnitude of 32768 fits in 5 digits, so no overflow condition exists.
  - 0 gives all digits 0 with `o_sign=OFF`.
- Output registers (digits, `o_sign`) change only on entry to DONE and hold between conversions.
- **Reset:** asserting `rst_n` low at any time, including mid-SHIFT, forces:
  - the FSM to IDLE and `cnt=0`;
  - `o_busy=0`, `o_done=0`;
  - all digits `4'h0`, `o_sign=OFF`.
  - The in-flight conversion is discarded, and no `o_done` is issued for it.

## Timing
- Edge E0 samples `i_start`/`i_data`.
- SHIFT occupies the cycles after E0 through E16; `o_busy=1` for exactly 16 cycles.
- After E16, `o_done=1` and new outputs are visible in the same cycle.
- Latency from the accepting edge to the `o_done` cycle is 16 cycles.
- Back-to-back throughput is one conversion per 17 cycles.
- `o_busy` and `o_done` are never high simultaneously.
- All outputs are registered; there is no combinational path from `i_start` or `i_data` to any output.

## Configuration
- **`DISP_BLANK_EN` defined:** leading-zero blanking.
  - Positions above the most significant nonzero digit are driven with `BLANK_CODE`.
  - `digit0` is never blanked, so value 0 shows a single 0.
  - `o_sign` is unaffected.
  - Blanking is computed when the output registers load, so it adds no extra cycle.
- **Not defined:** all five digits are output as plain BCD, including leading zeros, and `BLANK_CODE` is unused.

## Test plan
- Reset, then idle → `o_busy=0`, `o_done=0`, digits 0,0,0,0,0, `o_sign=OFF`.
- Start with `i_data=16'sd1234` → `o_done` 16 cycles after the accepting edge; digits (4..0) = 0,1,2,3,4; `o_sign=OFF`.
  - With `DISP_BLANK_EN`: digits (4..0) = F,1,2,3,4.
- Start with `i_data=-32768` → digits 3,2,7,6,8, `o_sign=TEN`.
  - Then start with `-1` in the DONE cycle → second `o_done` 17 cycles after the first; digits 0,0,0,0,1, `o_sign=TEN`.
- Start with 500, then pulse `i_start` with `i_data=999` at SHIFT cycle 5 → result is 500, exactly one `o_done`, and `o_busy` stays high for 16 cycles.
- Start with 7, then assert `rst_n` low at SHIFT cycle 8 and release → no `o_done`, outputs at reset values; a new start with 0 yields all zeros, `o_sign=OFF`.
